// File: rtl/ififo_skew.sv
// ififo_skew -- row-wide input FIFO feeding a systolic array, with optional
// diagonal read skew so lane i is popped i cycles after lane 0.
//
// Build option:
//   IFIFO_SKEW_EN  defined   : a pop launched by rd reaches lane i i edges later.
//                  undefined : all lanes pop on the edge that samples rd; o_busy = 0.
//
// Parameters:
//   row   - number of lanes (at least 2)
//   bw    - bits per lane word
//   depth - entries per lane (power of two, at least 2)
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high reset
//   in       - write row, lane i at [bw*(i+1)-1 : bw*i]
//   wr       - push one row into all lanes (dropped while o_full)
//   rd       - launch a pop of one row
//   out      - registered lane outputs, same mapping as in
//   o_valid  - per-lane strobe: lane holds a freshly popped word this cycle
//   o_full   - some lane holds depth entries
//   o_ready  - not o_full
//   o_empty  - every lane is empty
//   o_busy   - skewed lane pops still in flight
module ififo_skew #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [row*bw-1:0] in,
    input  logic              wr,
    input  logic              rd,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty,
    output logic              o_busy
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [row-1:0] lane_req;
    logic [row-1:0] lane_full;
    logic [row-1:0] lane_empty;
    logic           wr_en;

`ifdef IFIFO_SKEW_EN
    // pend[j] carries a request destined for lane j+1; lane 0 uses rd directly.
    logic [row-2:0] pend;

    always_comb begin
        lane_req = {pend, rd};
        o_busy   = |pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= lane_req[row-2:0];
        end
    end
`else
    always_comb begin
        lane_req = {row{rd}};
        o_busy   = 1'b0;
    end
`endif

    always_comb begin
        o_full  = |lane_full;
        o_ready = ~o_full;
        o_empty = &lane_empty;
        wr_en   = wr & ~o_full & ~reset;
    end

    for (genvar i = 0; i < row; i++) begin : g_lane
        logic [bw-1:0] mem [depth];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] count;
        logic [bw-1:0] lane_out;
        logic          lane_vld;
        logic          pop;

        assign lane_full[i]  = (count == CW'(depth));
        assign lane_empty[i] = (count == '0);
        assign pop           = lane_req[i] & ~lane_empty[i];
        assign out[bw*i +: bw] = lane_out;
        assign o_valid[i]      = lane_vld;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wptr] <= in[bw*i +: bw];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                lane_out <= '0;
                lane_vld <= 1'b0;
            end else begin
                lane_vld <= pop;
                if (wr_en) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr     <= rptr + 1'b1;
                    lane_out <= mem[rptr];
                end
                // Simultaneous push and pop leaves the lane count unchanged.
                case ({wr_en, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ififo_skew.sv
// Testbench for ififo_skew (row=8, bw=4, depth=8). Follows IFIFO_SKEW_EN:
// define it for the skewed build, leave it undefined for the flat build.
module tb_ififo_skew;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [31:0] in    = '0;
    logic [31:0] out;
    logic [7:0]  o_valid;
    logic        o_full;
    logic        o_ready;
    logic        o_empty;
    logic        o_busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ififo_skew #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_empty (o_empty),
        .o_busy  (o_busy)
    );

    // Reference model: per-lane queues; one expected output record per edge.
    typedef struct packed {
        logic [7:0]  v;
        logic [31:0] o;
        logic        full;
        logic        empty;
        logic        busy;
    } exp_t;

    logic [3:0]  mq [ROW][$];
    exp_t        sb [$];
    logic        armed = 1'b0;
    logic [6:0]  mpend = '0;
    logic [7:0]  mreq;
    logic [7:0]  ev = '0;
    logic [31:0] eo = '0;
    logic        mfull;
    logic        mempty;
    exp_t        epush;
    exp_t        epop;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < ROW; i++) mq[i].delete();
            mpend = '0;
            ev    = '0;
            eo    = '0;
            armed = 1'b1;
        end else if (armed) begin
            mfull = 1'b0;
            for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) mfull = 1'b1;
`ifdef IFIFO_SKEW_EN
            mreq  = {mpend, rd};
            mpend = mreq[6:0];
`else
            mreq  = {ROW{rd}};
            mpend = '0;
`endif
            ev = '0;
            for (int i = 0; i < ROW; i++) begin
                if (mreq[i] && mq[i].size() != 0) begin
                    eo[4*i +: 4] = mq[i].pop_front();
                    ev[i] = 1'b1;
                end
            end
            if (wr && !mfull) begin
                for (int i = 0; i < ROW; i++) mq[i].push_back(in[4*i +: 4]);
            end
        end
        if (armed) begin
            mfull  = 1'b0;
            mempty = 1'b1;
            for (int i = 0; i < ROW; i++) begin
                if (mq[i].size() == DEPTH) mfull = 1'b1;
                if (mq[i].size() != 0) mempty = 1'b0;
            end
            epush.v     = ev;
            epush.o     = eo;
            epush.full  = mfull;
            epush.empty = mempty;
            epush.busy  = |mpend;
            sb.push_back(epush);
        end
    end

    // Scoreboard monitor: compares every cycle away from the rising edge.
    initial forever begin
        @(negedge clk);
        if (sb.size() != 0) begin
            epop = sb.pop_front();
            vectors++;
            if ({o_valid, out} !== {epop.v, epop.o}) begin
                miscompares++;
                $display("FAIL sb_data: got valid=%h out=%h want valid=%h out=%h",
                         o_valid, out, epop.v, epop.o);
            end
            vectors++;
            if ({o_full, o_ready, o_empty, o_busy} !== {epop.full, ~epop.full, epop.empty, epop.busy}) begin
                miscompares++;
                $display("FAIL sb_flags: got full/ready/empty/busy=%b%b%b%b want %b%b%b%b",
                         o_full, o_ready, o_empty, o_busy,
                         epop.full, ~epop.full, epop.empty, epop.busy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one edge worth of inputs; returns at the following falling edge.
    task automatic cyc(input logic w, input logic r, input logic [31:0] d);
        wr = w;
        rd = r;
        in = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = 1'b1; rd = 1'b1; in = '1;
        @(negedge clk);
        reset = 1'b0; wr = 1'b0; rd = 1'b0; in = '0;
        vectors++;
        if (out !== 32'h0) begin miscompares++; $display("FAIL reset_out: got %h want 00000000", out); end
        vectors++;
        if (o_valid !== 8'h00) begin miscompares++; $display("FAIL reset_valid: got %h want 00", o_valid); end
        vectors++;
        if ({o_full, o_ready, o_empty, o_busy} !== 4'b0110) begin
            miscompares++;
            $display("FAIL reset_flags: got full/ready/empty/busy=%b%b%b%b want 0110",
                     o_full, o_ready, o_empty, o_busy);
        end
    endtask

    task automatic test_skew();
        cyc(1'b1, 1'b0, 32'h76543210);
        cyc(1'b0, 1'b1, 32'h0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) cyc(1'b0, 1'b0, 32'h0);
`ifdef IFIFO_SKEW_EN
            vectors++;
            if (o_valid !== 8'(1 << j)) begin
                miscompares++;
                $display("FAIL skew_valid[%0d]: got %h want %h", j, o_valid, 8'(1 << j));
            end
            vectors++;
            if (out[4*j +: 4] !== 4'(j)) begin
                miscompares++;
                $display("FAIL skew_lane[%0d]: got %h want %h", j, out[4*j +: 4], 4'(j));
            end
            vectors++;
            if (o_busy !== (j <= 6)) begin
                miscompares++;
                $display("FAIL skew_busy[%0d]: got %b want %b", j, o_busy, (j <= 6));
            end
`else
            vectors++;
            if (o_valid !== ((j == 0) ? 8'hFF : 8'h00)) begin
                miscompares++;
                $display("FAIL flat_valid[%0d]: got %h want %h", j, o_valid, (j == 0) ? 8'hFF : 8'h00);
            end
            vectors++;
            if (o_busy !== 1'b0) begin miscompares++; $display("FAIL flat_busy[%0d]: got %b want 0", j, o_busy); end
`endif
        end
        vectors++;
        if (out !== 32'h76543210) begin miscompares++; $display("FAIL skew_row: got %h want 76543210", out); end
        cyc(1'b0, 1'b0, 32'h0);
        vectors++;
        if ({o_valid, o_empty} !== 9'b0_0000_0001) begin
            miscompares++;
            $display("FAIL skew_idle: got valid=%h empty=%b want valid=00 empty=1", o_valid, o_empty);
        end
    endtask

    task automatic test_full();
        logic [3:0] nxt [ROW];
        for (int r = 0; r < 8; r++) cyc(1'b1, 1'b0, {8{4'(r)}});
        vectors++;
        if ({o_full, o_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_flags: got full=%b ready=%b want full=1 ready=0", o_full, o_ready);
        end
        cyc(1'b1, 1'b0, 32'hFFFFFFFF);
        vectors++;
        if ({o_full, o_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_after_drop: got full=%b ready=%b want full=1 ready=0", o_full, o_ready);
        end
        for (int i = 0; i < ROW; i++) nxt[i] = 4'h0;
        for (int c = 0; c < 16; c++) begin
            cyc(1'b0, (c < 8), 32'h0);
            for (int i = 0; i < ROW; i++) begin
                if (o_valid[i]) begin
                    vectors++;
                    if (out[4*i +: 4] !== nxt[i]) begin
                        miscompares++;
                        $display("FAIL full_pop_lane%0d: got %h want %h", i, out[4*i +: 4], nxt[i]);
                    end
                    nxt[i] = nxt[i] + 4'h1;
                end
            end
        end
        for (int i = 0; i < ROW; i++) begin
            vectors++;
            if (nxt[i] !== 4'h8) begin
                miscompares++;
                $display("FAIL full_pop_count_lane%0d: got %0d pops want 8", i, nxt[i]);
            end
        end
        vectors++;
        if (o_empty !== 1'b1) begin miscompares++; $display("FAIL full_drained: got empty=%b want 1", o_empty); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 6; r++) cyc(1'b1, 1'b0, $urandom);
        for (int r = 0; r < 6; r++) cyc(1'b0, 1'b1, 32'h0);
        for (int r = 0; r < 8; r++) cyc(1'b0, 1'b0, 32'h0);
        vectors++;
        if (o_empty !== 1'b1) begin miscompares++; $display("FAIL wrap1_empty: got %b want 1", o_empty); end
        cyc(1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b0, $urandom);
        for (int r = 0; r < 4; r++) cyc(1'b1, 1'b1, $urandom);
        cyc(1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h0);
        for (int r = 0; r < 8; r++) cyc(1'b0, 1'b0, 32'h0);
        vectors++;
        if ({o_empty, o_busy, o_full} !== 3'b100) begin
            miscompares++;
            $display("FAIL wrap2_final: got empty/busy/full=%b%b%b want 100", o_empty, o_busy, o_full);
        end
    endtask

    task automatic test_empty_rd();
        logic [31:0] row_v;
        logic [31:0] got;
        logic [7:0]  seen;
        cyc(1'b0, 1'b1, 32'h0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) cyc(1'b0, 1'b0, 32'h0);
            vectors++;
            if (o_valid !== 8'h00) begin
                miscompares++;
                $display("FAIL empty_rd_valid[%0d]: got %h want 00", j, o_valid);
            end
        end
        row_v = 32'h9E5CA1B3;
        got   = '0;
        seen  = '0;
        cyc(1'b1, 1'b0, row_v);
        cyc(1'b0, 1'b1, 32'h0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) cyc(1'b0, 1'b0, 32'h0);
            for (int i = 0; i < ROW; i++) begin
                if (o_valid[i]) begin
                    got[4*i +: 4] = out[4*i +: 4];
                    seen[i] = 1'b1;
                end
            end
        end
        vectors++;
        if ({seen, got} !== {8'hFF, row_v}) begin
            miscompares++;
            $display("FAIL empty_rd_next_row: got lanes=%h row=%h want lanes=ff row=%h", seen, got, row_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seen;
        seen = '0;
        cyc(1'b1, 1'b0, 32'h11111111);
        cyc(1'b1, 1'b0, 32'h22222222);
        cyc(1'b0, 1'b1, 32'h0);
        seen |= o_valid;
        cyc(1'b0, 1'b0, 32'h0);
        seen |= o_valid;
        reset = 1'b1; wr = 1'b1; rd = 1'b1; in = 32'hABCDEF01;
        @(negedge clk);
        seen |= o_valid;
        reset = 1'b0; wr = 1'b0; rd = 1'b0; in = '0;
        vectors++;
        if ({o_empty, o_busy, out} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_state: got empty=%b busy=%b out=%h want empty=1 busy=0 out=00000000",
                     o_empty, o_busy, out);
        end
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 1'b0, 32'h0);
            seen |= o_valid;
        end
`ifdef IFIFO_SKEW_EN
        vectors++;
        if (seen !== 8'h03) begin miscompares++; $display("FAIL reset_mid_lanes: got %h want 03", seen); end
`else
        vectors++;
        if (seen !== 8'hFF) begin miscompares++; $display("FAIL reset_mid_lanes: got %h want ff", seen); end
`endif
        vectors++;
        if ({o_empty, o_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_after: got empty=%b busy=%b want empty=1 busy=0", o_empty, o_busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_skew();
        test_full();
        test_wrap();
        test_empty_rd();
        test_reset_mid();
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
